// File: rtl/fpga_debug_monitor.sv
// fpga_debug_monitor: status LEDs, saturating write counter and a steppable trace of recent data-memory writes.
// Define DEBUG_MON_STRETCH_EN to build the LED pulse stretchers; otherwise events are only registered.
module fpga_debug_monitor #(
    parameter int LED_W = 4,
    parameter int DEPTH = 8,
    parameter int STRETCH_CYCLES = 2500000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             memwrite,
    input  logic [31:0]      dataadr,
    input  logic [31:0]      writedata,
    input  logic             zero,
    input  logic             freeze,
    input  logic             step,
    input  logic [1:0]       mode,
    output logic [LED_W-1:0] led,
    output logic [15:0]      wr_count,
    output logic             trace_valid,
    output logic [31:0]      trace_adr,
    output logic [31:0]      trace_data
);
    localparam int aw = $clog2(DEPTH);
    localparam logic [aw:0] full = (aw+1)'(DEPTH);

    if (LED_W < 4 || DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0 || STRETCH_CYCLES < 2) begin : g_bad_params
        $error("fpga_debug_monitor: illegal parameter set");
    end

    logic [31:0] adr_mem [DEPTH];
    logic [31:0] data_mem [DEPTH];
    logic [aw-1:0] wr_ptr, rd_idx, sel;
    logic [aw:0] fill;
    logic capture, str_mw, str_zero;
    logic [LED_W-1:0] live, led_next;

    assign capture = memwrite && !freeze;
    // rd_idx counts from the oldest entry, which sits fill slots behind wr_ptr
    assign sel = wr_ptr - fill[aw-1:0] + rd_idx;
    assign trace_valid = fill != '0;
    assign trace_adr = trace_valid ? adr_mem[sel] : '0;
    assign trace_data = trace_valid ? data_mem[sel] : '0;

    always_ff @(posedge clk)
        if (!reset && capture) begin
            adr_mem[wr_ptr] <= dataadr;
            data_mem[wr_ptr] <= writedata;
        end

    always_ff @(posedge clk)
        if (reset) begin
            wr_count <= '0;
            wr_ptr <= '0;
            fill <= '0;
            rd_idx <= '0;
        end else begin
            if (memwrite && wr_count != 16'hffff)
                wr_count <= wr_count + 16'd1;
            if (capture) begin
                wr_ptr <= wr_ptr + aw'(1);
                if (fill != full)
                    fill <= fill + (aw+1)'(1);
            end
            if (step && trace_valid)
                rd_idx <= ({1'b0, rd_idx} == fill - (aw+1)'(1)) ? '0 : rd_idx + aw'(1);
        end

`ifdef DEBUG_MON_STRETCH_EN
    localparam int cw = $clog2(STRETCH_CYCLES);
    localparam logic [cw-1:0] reload = cw'(STRETCH_CYCLES - 1);
    logic [cw-1:0] cnt_mw, cnt_zero;

    always_ff @(posedge clk)
        if (reset) begin
            cnt_mw <= '0;
            cnt_zero <= '0;
        end else begin
            cnt_mw <= memwrite ? reload : (cnt_mw != '0) ? cnt_mw - cw'(1) : '0;
            cnt_zero <= zero ? reload : (cnt_zero != '0) ? cnt_zero - cw'(1) : '0;
        end

    assign str_mw = memwrite || cnt_mw != '0;
    assign str_zero = zero || cnt_zero != '0;
`else
    assign str_mw = memwrite;
    assign str_zero = zero;
`endif

    always_comb begin
        live = '0;
        live[0] = str_mw;
        live[1] = |dataadr[31:24];
        live[2] = |writedata[31:24];
        live[3] = str_zero;
    end

    assign led_next = (mode == 2'd0) ? live :
                      (mode == 2'd1) ? wr_count[LED_W-1:0] :
                      (mode == 2'd2) ? trace_adr[LED_W+1:2] : trace_data[LED_W-1:0];

    always_ff @(posedge clk)
        led <= reset ? '0 : led_next;
endmodule

// File: doc/fpga_debug_monitor.md
# fpga_debug_monitor

Parametrised board-level observation block between the MIPS `top` and the FPGA pins. It replaces fixed LED wiring with the following:
- pulse-stretched status LEDs;
- a saturating memory-write counter;
- a circular trace buffer of the last `DEPTH` data-memory writes, which can be stepped through on the LEDs.

It consumes only the processor's external bus signals (`memwrite`, `dataadr`, `writedata`) plus the ALU `zero` flag.

## Interface
- `LED_W`, 4, number of LED outputs (≥4)
- `DEPTH`, 8, trace entries; power of two, 2..64
- `STRETCH_CYCLES`, 2500000, LED on-time for a one-cycle event (≥2)
- `clk` input 1: single clock domain
- `reset` input 1: synchronous, active-high
- `memwrite` input 1: processor data-memory write strobe
- `dataadr` input 32: write address
- `writedata` input 32: write data
- `zero` input 1: ALU zero flag
- `freeze` input 1: level; when 1, trace capture is suspended
- `step` input 1: one-cycle pulse, pre-debounced; advances trace read index
- `mode` input 2: LED source select
- `led` output LED_W: registered LED drive
- `wr_count` output 16: saturating count of memwrite cycles
- `trace_valid` output 1: at least one trace entry held
- `trace_adr` output 32: address of selected entry
- `trace_data` output 32: data of selected entry

## Operation
- **Write counter:** `wr_count` increments on every cycle with `memwrite`=1, regardless of `freeze`. It holds at 0xFFFF.
- **Trace capture:** on `memwrite`=1 and `freeze`=0, the block stores {`dataadr`, `writedata`} at `wr_ptr`. `wr_ptr` then increments mod DEPTH.
  - `fill` (0..DEPTH) increments, saturating at DEPTH.
  - When full, the oldest entry is overwritten.
- **Read index:** `rd_idx` is the offset from the oldest valid entry, range 0..`fill`-1.
  - Selected slot = (`wr_ptr` − `fill` + `rd_idx`) mod DEPTH.
  - `step` with `fill`=0: no effect.
  - Otherwise `rd_idx` increments, wrapping from `fill`-1 to 0.
  - A capture that overwrites while full leaves `rd_idx` unchanged, so the selected slot shifts with the window.
- **Trace outputs:** `trace_adr`/`trace_data` are combinational from the selected slot. `trace_valid` = (`fill`≠0). With `fill`=0, `trace_adr`/`trace_data` = 0.
- **Stretcher (per event, for memwrite and zero):**
  - Input 1: countdown loads STRETCH_CYCLES−1.
  - Else, if countdown ≠0: countdown decrements.
  - Stretched = input OR (countdown ≠0).
- **LED mapping** (registered; bits not listed drive 0):
  - `mode`=0 live: `led[0]`=stretched memwrite, `led[1]`=|`dataadr[31:24]`, `led[2]`=|`writedata[31:24]`, `led[3]`=stretched zero.
  - `mode`=1: `wr_count[LED_W-1:0]`.
  - `mode`=2: `trace_adr[LED_W+1:2]` (word address).
  - `mode`=3: `trace_data[LED_W-1:0]`.

## Timing
- Reset (synchronous, dominates all other inputs): `led`=0, `wr_count`=0, `fill`=0, `wr_ptr`=0, `rd_idx`=0, both countdowns=0. Hence `trace_valid`=0 and `trace_adr`=`trace_data`=0. Trace storage contents need not be cleared.
- Capture: an entry written at edge t is visible on the trace outputs from cycle t+1.
- `wr_count`, `fill` and `rd_idx` update at the same edge as their triggering input.
- `led` has one-cycle latency from its source.
  - Stretched one-cycle event at cycle t: LED high in cycles t+1..t+STRETCH_CYCLES, low at t+STRETCH_CYCLES+1.
  - A retrigger reloads the countdown.
- Same-cycle capture and `step`: both apply. `rd_idx` wrap uses the pre-edge `fill`.
- Mode change: takes effect on `led` one cycle later.
- Reset mid-stretch or mid-capture: all state clears in the same edge; any write in that cycle is not recorded.

## Configuration
- `DEBUG_MON_STRETCH_EN`
  - Defined: stretchers built as above.
  - Undefined: no countdown logic; `led[0]`/`led[3]` in `mode` 0 are the raw `memwrite`/`zero` registered one cycle. `STRETCH_CYCLES` is ignored.

## Test plan
Parameters for all scenarios: LED_W=4, DEPTH=4, STRETCH_CYCLES=4, macro defined.
1. Reset, then `mode`=0, `memwrite` pulse for 1 cycle at t → `led[0]`=1 for cycles t+1..t+4, 0 at t+5; `wr_count`=1.
2. Six writes, adr 0x10,0x14,…,0x24, data 1..6 → `fill`=4, oldest adr 0x18/data 3; `step`×3 → adr 0x24; 4th `step` → back to 0x18.
3. `freeze`=1, three writes → trace unchanged, `wr_count` +3; `freeze`=0, one write adr 0x40 → newest entry 0x40.
4. `mode`=2 with selected adr 0x0000_0024 → `led`=4'b1001 one cycle after the mode change; `mode`=3 with data 6 → `led`=4'b0110.
5. `step` with `fill`=0 → `rd_idx` stays 0, `trace_valid`=0; reset asserted during an active stretch → `led`=0 the next cycle.
6. Force `wr_count`=0xFFFE, then two writes → `wr_count`=0xFFFF and holds; rebuild without macro → `led[0]` high exactly 1 cycle, at t+1.
